mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, number of 16-bit RAM words (power of two, 2..16384).
REQ-002 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 i_mem_addr  input  16  byte address from bus master.
REQ-006 i_mem_rd  input  1  read strobe, one access per asserted cycle.
REQ-007 i_mem_wr  input  1  write strobe, one access per asserted cycle.
REQ-008 i_mem_wrdata  input  16  write data.
REQ-009 o_mem_rddata  output  16  registered read data.
REQ-010 o_out_data  output  16  FIFO head word.
REQ-011 o_out_valid  output  1  FIFO non-empty.
REQ-012 i_out_ready  input  1  downstream accepts head word.

Function
REQ-013 Decode: addr[15]=0 -> RAM, word index addr[log2(RAM_WORDS):1] (higher bits ignored, aliasing wraps); addr[0] ignored everywhere; addr[15]=1 -> MMIO.
REQ-014 MMIO map (word, addr[0] ignored): 0x8000 OUTDATA (write = push), 0x8002 STATUS, 0x8004 CYCLES; other MMIO addresses read 0x0000, writes ignored.
REQ-015 STATUS read: [4:0] FIFO count, [8] full, [9] empty, [10] sticky overflow, others 0; any write to STATUS clears overflow.
REQ-016 Read latency exactly 1 cycle: data for i_mem_rd in cycle N appears on o_mem_rddata in cycle N+1.
REQ-017 o_mem_rddata holds its last value in cycles following no read.
REQ-018 RAM write commits at the edge ending the cycle with i_mem_wr=1, full 16 bits.
REQ-019 i_mem_rd and i_mem_wr same cycle, same address: write performed, read returns pre-write (old) data; MMIO reads likewise return pre-edge state.
REQ-020 Push when not full: entry appended, count+1 next cycle.
REQ-021 Push when full and no same-cycle pop: data dropped, overflow set to 1, count unchanged.
REQ-022 Pop occurs when o_out_valid=1 and i_out_ready=1; head advances next cycle.
REQ-023 Push and pop same cycle when full: both succeed, count unchanged, no overflow.
REQ-024 Push when empty: o_out_valid rises next cycle; a same-cycle ready has no effect.
REQ-025 o_out_data and o_out_valid stable while o_out_valid=1 and i_out_ready=0.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 CYCLES: 16-bit counter increments every cycle, wraps 0xFFFF -> 0x0000; write loads i_mem_wrdata, increment resumes from loaded value next cycle.

Reset
REQ-028 On reset: o_mem_rddata=0, o_out_data=0, o_out_valid=0, FIFO count=0, pointers=0, overflow=0, CYCLES=0.
REQ-029 RAM contents not reset.
REQ-030 Reset asserted between a read strobe and its data cycle: read discarded, o_mem_rddata=0 after reset release until a new read.
REQ-031 Strobes during reset ignored; no RAM writes, no pushes.

Configuration
REQ-032 Macro MEM_RESPONDER_CYCLES_EN: defined -> CYCLES counter per REQ-027; undefined -> no counter logic, 0x8004 reads 0x0000, writes ignored.

Verification
REQ-033 Write 0x1234 to 0x0010, read 0x0010 next cycle -> o_mem_rddata=0x1234 one cycle after read strobe; read 0x0011 -> 0x1234.
REQ-034 RAM_WORDS=256: write 0xBEEF to 0x0002, read 0x0202 -> 0xBEEF (alias).
REQ-035 i_out_ready=0, push 0x0001..0x0005 -> STATUS=0x0504 (count 4, full, overflow); write STATUS -> overflow 0; ready=1 -> drains 0x0001..0x0004 in order, o_out_valid falls, STATUS=0x0200.
REQ-036 FIFO full, push 0x00AA with ready=1 same cycle -> count stays 4, overflow 0, 0x00AA last out.
REQ-037 Macro defined: write 0xFFFE to 0x8004, read 0x8004 two cycles later -> 0x0000 (wrap); undefined -> 0x0000 always.
REQ-038 Read strobe then reset pulse before next edge -> o_mem_rddata=0, o_out_valid=0, STATUS=0x0200 after release.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-mapped responder: a word RAM, an output FIFO fed through an MMIO port, and a status register.
// Optional free-running CYCLES counter at 0x8004, enabled by defining MEM_RESPONDER_CYCLES_EN.
module mem_responder #(
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] i_mem_addr,
   input  logic        i_mem_rd,
   input  logic        i_mem_wr,
   input  logic [15:0] i_mem_wrdata,
   output logic [15:0] o_mem_rddata,
   output logic [15:0] o_out_data,
   output logic        o_out_valid,
   input  logic        i_out_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_OUTDATA,
      SEL_STATUS,
      SEL_CYCLES,
      SEL_NONE
   } sel_t;

   sel_t        sel;
   logic [15:0] rd_mux;
   logic [15:0] status_word;
   logic [15:0] cycles_val;
   logic        unused_addr;

   // addr[0] and RAM index bits above log2(RAM_WORDS) are deliberately ignored.
   assign unused_addr = ^i_mem_addr;

   // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      sel = SEL_NONE;
      if (!i_mem_addr[15]) begin
         sel = SEL_RAM;
      end else begin
         case (i_mem_addr[14:1])
            14'h0000: sel = SEL_OUTDATA;
            14'h0001: sel = SEL_STATUS;
            14'h0002: sel = SEL_CYCLES;
            default:  sel = SEL_NONE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RAM
   logic [15:0]   ram [RAM_WORDS];
   logic [AW-1:0] ram_idx;

   assign ram_idx = i_mem_addr[AW:1];

   // NOTE: the RAM array has no reset so it maps onto memory cells; writes are gated while reset is high.
   always_ff @(posedge clk) begin
      if (i_mem_wr && !reset && sel == SEL_RAM) begin
         ram[ram_idx] <= i_mem_wrdata;
      end
   end

   // ---------------------------------------------------------------- output FIFO
   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [4:0]    count;
   logic [4:0]    count_next;
   logic          overflow;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push_ok;
   logic          pop;

   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == 5'd0);
   assign pop      = !empty && i_out_ready;
   assign push_req = i_mem_wr && sel == SEL_OUTDATA;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign push_ok  = push_req && (!full || pop);

   always_comb begin
      count_next = count;
      if (push_ok && !pop) begin
         count_next = count + 5'd1;
      end else if (!push_ok && pop) begin
         count_next = count - 5'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         count <= count_next;
         if (push_ok) begin
            fifo_mem[wr_ptr] <= i_mem_wrdata;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (i_mem_wr && sel == SEL_STATUS) begin
         overflow <= 1'b0;
      end else if (push_req && !push_ok) begin
         overflow <= 1'b1;
      end
   end

   assign o_out_valid = !empty;
   assign o_out_data  = fifo_mem[rd_ptr];

   assign status_word = {5'b0, overflow, empty, full, 3'b0, count};

   // ---------------------------------------------------------------- CYCLES
`ifdef MEM_RESPONDER_CYCLES_EN
   logic [15:0] cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles <= '0;
      end else if (i_mem_wr && sel == SEL_CYCLES) begin
         cycles <= i_mem_wrdata;
      end else begin
         cycles <= cycles + 16'd1;
      end
   end

   assign cycles_val = cycles;
`else
   assign cycles_val = '0;
`endif

   // ---------------------------------------------------------------- read path
   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_RAM:    rd_mux = ram[ram_idx];
         SEL_STATUS: rd_mux = status_word;
         SEL_CYCLES: rd_mux = cycles_val;
         default:    rd_mux = '0;
      endcase
   end

   // A reset between strobe and data cycle leaves zero here until the next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_mem_rddata <= '0;
      end else if (i_mem_rd) begin
         o_mem_rddata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_responder;

   localparam int RAM_WORDS  = 256;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        ready = 1'b0;
   logic [15:0] rddata;
   logic [15:0] out_data;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   mem_responder #(
      .RAM_WORDS (RAM_WORDS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_mem_addr  (addr),
      .i_mem_rd    (rd),
      .i_mem_wr    (wr),
      .i_mem_wrdata(wdata),
      .o_mem_rddata(rddata),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- behavioural model
   logic [15:0] m_ram [RAM_WORDS];
   logic [15:0] m_q [$];
   bit          m_ovf;
   logic [15:0] m_cyc;
   logic [15:0] m_rd;
   logic [15:0] m_word;
   bit          m_pop;
   bit          m_full;

   function automatic logic [15:0] m_status();
      int n;
      n = m_q.size();
      return 16'(n) | (n == FIFO_DEPTH ? 16'h0100 : 16'h0000) |
             (n == 0 ? 16'h0200 : 16'h0000) | (m_ovf ? 16'h0400 : 16'h0000);
   endfunction

   function automatic logic [15:0] m_read(input logic [15:0] a);
      if (a < 16'h8000) return m_ram[(a >> 1) % RAM_WORDS];
      case (a & 16'hFFFE)
         16'h8002: return m_status();
         16'h8004: begin
`ifdef MEM_RESPONDER_CYCLES_EN
            return m_cyc;
`else
            return 16'h0000;
`endif
         end
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_cyc = 16'h0000;
         m_rd  = 16'h0000;
      end else begin
         m_word = addr & 16'hFFFE;
         if (rd) m_rd = m_read(addr);
         m_pop  = (m_q.size() > 0) && ready;
         m_full = (m_q.size() == FIFO_DEPTH);
         if (m_pop) void'(m_q.pop_front());
         if (wr) begin
            if (addr < 16'h8000) begin
               m_ram[(addr >> 1) % RAM_WORDS] = wdata;
            end else if (m_word == 16'h8000) begin
               if (!m_full || m_pop) m_q.push_back(wdata);
               else m_ovf = 1'b1;
            end else if (m_word == 16'h8002) begin
               m_ovf = 1'b0;
            end
         end
         if (wr && m_word == 16'h8004) m_cyc = wdata;
         else m_cyc = m_cyc + 16'd1;
      end
   end

   // ---------------------------------------------------------------- compare process
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("rddata", rddata, m_rd);
         check("valid", {15'b0, out_valid}, (m_q.size() != 0) ? 16'h0001 : 16'h0000);
         if (m_q.size() != 0) check("head", out_data, m_q[0]);
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
      rd = r;
      wr = w;
      addr = a;
      wdata = d;
      tick();
      rd = 1'b0;
      wr = 1'b0;
   endtask

   task automatic idle(input int n);
      rd = 1'b0;
      wr = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      logic [15:0] last;
      logic [15:0] a;

      reset = 1'b1;
      repeat (3) tick();
      check("rst_rddata", rddata, 16'h0000);
      check("rst_valid", {15'b0, out_valid}, 16'h0000);
      check("rst_head", out_data, 16'h0000);
      reset = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < RAM_WORDS; i++) bus(1'b0, 1'b1, 16'(2 * i), 16'($urandom));

      // Basic write/read, odd byte address, hold after idle.
      bus(1'b0, 1'b1, 16'h0010, 16'h1234);
      bus(1'b1, 1'b0, 16'h0010, 16'h0000);
      check("rd_0010", rddata, 16'h1234);
      bus(1'b1, 1'b0, 16'h0011, 16'h0000);
      check("rd_0011", rddata, 16'h1234);
      idle(2);
      check("rd_hold", rddata, 16'h1234);

      // Aliasing above the RAM index bits.
      bus(1'b0, 1'b1, 16'h0002, 16'hBEEF);
      bus(1'b1, 1'b0, 16'h0202, 16'h0000);
      check("rd_alias", rddata, 16'hBEEF);

      // Same-cycle read and write returns old data.
      bus(1'b1, 1'b1, 16'h0010, 16'h5555);
      check("rd_during_wr", rddata, 16'h1234);
      bus(1'b1, 1'b0, 16'h0010, 16'h0000);
      check("rd_after_wr", rddata, 16'h5555);

      // Overflow, clear, in-order drain.
      ready = 1'b0;
      for (int k = 1; k <= 5; k++) bus(1'b0, 1'b1, 16'h8000, 16'(k));
      bus(1'b1, 1'b0, 16'h8002, 16'h0000);
      check("status_full_ovf", rddata, 16'h0504);
      bus(1'b0, 1'b1, 16'h8002, 16'h0000);
      bus(1'b1, 1'b0, 16'h8003, 16'h0000);
      check("status_ovf_clr", rddata, 16'h0104);
      ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("drain_head", out_data, 16'(k));
         tick();
      end
      check("drain_empty", {15'b0, out_valid}, 16'h0000);
      bus(1'b1, 1'b0, 16'h8002, 16'h0000);
      check("status_empty", rddata, 16'h0200);

      // Push and pop together while full.
      ready = 1'b0;
      for (int k = 0; k < 4; k++) bus(1'b0, 1'b1, 16'h8000, 16'(16'h0010 + k));
      ready = 1'b1;
      bus(1'b0, 1'b1, 16'h8000, 16'h00AA);
      bus(1'b1, 1'b0, 16'h8002, 16'h0000);
      check("status_push_pop_full", rddata, 16'h0104);
      last = 16'h0000;
      for (int g = 0; g < 20 && out_valid; g++) begin
         last = out_data;
         tick();
      end
      check("last_out", last, 16'h00AA);
      check("drained", {15'b0, out_valid}, 16'h0000);

      // CYCLES register.
`ifdef MEM_RESPONDER_CYCLES_EN
      bus(1'b0, 1'b1, 16'h8004, 16'hFFFE);
      bus(1'b1, 1'b0, 16'h8004, 16'h0000);
      check("cycles_loaded", rddata, 16'hFFFE);
      idle(1);
      bus(1'b1, 1'b0, 16'h8004, 16'h0000);
      check("cycles_wrap", rddata, 16'h0000);
`else
      bus(1'b1, 1'b1, 16'h8005, 16'h7000);
      bus(1'b1, 1'b0, 16'h8004, 16'h0000);
      check("cycles_absent", rddata, 16'h0000);
`endif

      // Unmapped MMIO.
      bus(1'b1, 1'b0, 16'h0010, 16'h0000);
      bus(1'b0, 1'b1, 16'h8006, 16'hFFFF);
      bus(1'b1, 1'b0, 16'h8007, 16'h0000);
      check("unmapped", rddata, 16'h0000);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: a = 16'($urandom) & 16'h7FFF;
            4:          a = 16'h8000 | 16'($urandom_range(0, 1));
            5:          a = 16'h8002;
            6:          a = 16'h8004;
            default:    a = 16'h8000 | 16'($urandom);
         endcase
         ready = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      end

      // Reset between a read strobe and its data cycle.
      ready = 1'b0;
      bus(1'b0, 1'b1, 16'h0020, 16'h7777);
      bus(1'b0, 1'b1, 16'h8000, 16'h0042);
      bus(1'b1, 1'b0, 16'h0020, 16'h0000);
      check("pre_rst_read", rddata, 16'h7777);
      rd = 1'b1;
      addr = 16'h0020;
      @(negedge clk);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      rd = 1'b0;
      tick();
      check("post_rst_rddata", rddata, 16'h0000);
      check("post_rst_valid", {15'b0, out_valid}, 16'h0000);
      bus(1'b1, 1'b0, 16'h8002, 16'h0000);
      check("post_rst_status", rddata, 16'h0200);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
